mips_prog_loader: RTL

Boot-time program loader for `pipelined_mips_32`. It accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit words. Each payload word is written into the processor's unified memory, and the payload is checked against an XOR checksum. The processor is held halted with `pc` at 0 until the load completes cleanly. This replaces ad-hoc memory preloading: it is the stage directly upstream of the core and produces the memory image the core fetches from.

---
 rtl/mips_prog_loader.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/mips_prog_loader.sv
// Boot-time program loader for pipelined_mips_32.
// Takes a byte stream over valid/ready and assembles big-endian words. A frame
// is a header word, then N payload words written into core memory, then an XOR
// checksum word. The core stays halted with pc at 0 until the frame loads cleanly.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | post-reset cycle, moves to HDR unconditionally
// HDR   | collecting header word: [31:16] base address, [15:0] count
// DATA  | collecting payload words, one memory write per word
// CSUM  | collecting checksum word, compared against XOR accumulator
// DONE  | load succeeded, core released, waits for load_req
// ERR   | range or checksum failure, core held, waits for load_req

module mips_prog_loader #(
    parameter int ADDR_W = 10
) (
    input  logic              clk1,
    input  logic              rst_n,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              load_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              cpu_start,
    output logic              boot_done,
    output logic              boot_err
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR  = 3'd1,
        S_DATA = 3'd2,
        S_CSUM = 3'd3,
        S_DONE = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    // One past the last legal word address; header ranges are checked in 17 bits
    // so that base + count cannot wrap.
    localparam logic [16:0] ADDR_LIMIT = 17'(2 ** ADDR_W);

    state_t            state_q, state_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [23:0]       shift_q, shift_d;
    logic [15:0]       base_q, base_d;
    logic [15:0]       count_q, count_d;
    logic [15:0]       idx_q, idx_d;
    logic [31:0]       acc_q, acc_d;

    logic              in_ready_q, in_ready_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              cpu_hold_q, cpu_hold_d;
    logic              cpu_start_q, cpu_start_d;
    logic              boot_done_q, boot_done_d;
    logic              boot_err_q, boot_err_d;

    logic              accept;
    logic              word_done;
    logic [31:0]       word;
    logic [16:0]       hdr_end;
    logic [15:0]       idx_next;

    // Byte acceptance and word assembly from the three held bytes plus the current one.
    always_comb begin
        accept    = in_valid && in_ready_q;
        word_done = accept && (byte_cnt_q == 2'd3);
        word      = {shift_q, in_data};
        hdr_end   = {1'b0, word[31:16]} + {1'b0, word[15:0]};
        idx_next  = idx_q + 16'd1;
    end

    // Next-state and next-output logic for the loader FSM.
    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        shift_d     = shift_q;
        base_d      = base_q;
        count_d     = count_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_hold_d  = cpu_hold_q;
        cpu_start_d = 1'b0;
        boot_done_d = boot_done_q;
        boot_err_d  = boot_err_q;

        // The 2-bit counter wraps 3 -> 0, which is exactly the word boundary reset.
        if (accept) begin
            shift_d    = {shift_q[15:0], in_data};
            byte_cnt_d = byte_cnt_q + 2'd1;
        end

        case (state_q)
            S_IDLE: begin
                state_d    = S_HDR;
                byte_cnt_d = 2'd0;
            end

            S_HDR: begin
                if (word_done) begin
                    base_d  = word[31:16];
                    count_d = word[15:0];
                    idx_d   = 16'd0;
                    acc_d   = 32'd0;
                    if (hdr_end > ADDR_LIMIT) begin
                        state_d    = S_ERR;
                        cpu_hold_d = 1'b1;
                        boot_err_d = 1'b1;
                    end else if (word[15:0] == 16'd0) begin
                        state_d = S_CSUM;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end

            S_DATA: begin
                if (word_done) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = ADDR_W'(base_q + idx_q);
                    mem_wdata_d = word;
                    acc_d       = acc_q ^ word;
                    idx_d       = idx_next;
                    if (idx_next == count_q) begin
                        state_d = S_CSUM;
                    end
                end
            end

            S_CSUM: begin
                if (word_done) begin
                    if (word == acc_q) begin
                        state_d     = S_DONE;
                        cpu_hold_d  = 1'b0;
                        cpu_start_d = 1'b1;
                        boot_done_d = 1'b1;
                    end else begin
                        state_d    = S_ERR;
                        cpu_hold_d = 1'b1;
                        boot_err_d = 1'b1;
                    end
                end
            end

            S_DONE, S_ERR: begin
                if (load_req) begin
                    state_d     = S_HDR;
                    byte_cnt_d  = 2'd0;
                    cpu_hold_d  = 1'b1;
                    boot_done_d = 1'b0;
                    boot_err_d  = 1'b0;
                end
            end

            default: begin
                state_d    = S_IDLE;
                byte_cnt_d = 2'd0;
                cpu_hold_d = 1'b1;
            end
        endcase

        // Registered from the next state so in_ready lines up with the state register.
        in_ready_d = (state_d == S_HDR) || (state_d == S_DATA) || (state_d == S_CSUM);
    end

    // State and output registers; synchronous reset also drops any pending write.
    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            byte_cnt_q  <= 2'd0;
            shift_q     <= 24'd0;
            base_q      <= 16'd0;
            count_q     <= 16'd0;
            idx_q       <= 16'd0;
            acc_q       <= 32'd0;
            in_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'd0;
            cpu_hold_q  <= 1'b1;
            cpu_start_q <= 1'b0;
            boot_done_q <= 1'b0;
            boot_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            shift_q     <= shift_d;
            base_q      <= base_d;
            count_q     <= count_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            in_ready_q  <= in_ready_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_hold_q  <= cpu_hold_d;
            cpu_start_q <= cpu_start_d;
            boot_done_q <= boot_done_d;
            boot_err_q  <= boot_err_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_hold  = cpu_hold_q;
    assign cpu_start = cpu_start_q;
    assign boot_done = boot_done_q;
    assign boot_err  = boot_err_q;

endmodule
